// File: rtl/output_tx_arbiter_if.sv
// ----------------------------------------------------------------------------
// output_tx_arbiter_if
//   Bundles the three producer streams and the TX FIFO write port that the
//   output_tx_arbiter sits between.
//
//   Producer side (3 sources: 0=macroblock, 1=residual parser, 2=quantized parser)
//     src_en     [2:0]         per-source enable mask, sampled only at arbitration
//     src_data   [3*DATA_W-1:0] flattened source words, src i at [DATA_W*i +: DATA_W]
//     src_valid  [2:0]         source word valid
//     src_last   [2:0]         marks the final word of a burst
//     src_ready  [2:0]         word accepted when src_valid[i] & src_ready[i]
//   FIFO side
//     fifo_din   [DATA_W-1:0]  TX FIFO write data
//     fifo_wr_en               TX FIFO write strobe
//     fifo_full                no write may happen while high
//   Status
//     grant      [1:0]         current owner, 2'd3 = none
//     busy                     arbiter active or an enabled source is requesting
//
//   Modports
//     master : the arbiter (drives FIFO write port, ready, grant, busy)
//     slave  : the surrounding producers / FIFO
// ----------------------------------------------------------------------------
interface output_tx_arbiter_if #(
    parameter int DATA_W = 32
);
    logic [2:0]          src_en;
    logic [3*DATA_W-1:0] src_data;
    logic [2:0]          src_valid;
    logic [2:0]          src_last;
    logic [2:0]          src_ready;
    logic [DATA_W-1:0]   fifo_din;
    logic                fifo_wr_en;
    logic                fifo_full;
    logic [1:0]          grant;
    logic                busy;

    modport master (
        input  src_en, src_data, src_valid, src_last, fifo_full,
        output src_ready, fifo_din, fifo_wr_en, grant, busy
    );

    modport slave (
        output src_en, src_data, src_valid, src_last, fifo_full,
        input  src_ready, fifo_din, fifo_wr_en, grant, busy
    );
endinterface

// File: rtl/output_tx_arbiter.sv
// ----------------------------------------------------------------------------
// output_tx_arbiter
//   Round-robin scheduler sharing one TX FIFO write port between three
//   producers. Each grant covers one burst, which is prefixed by a header word
//   {8'hA5, 6'd0, grant, seq} so the host can demultiplex the interleaved
//   streams. Bursts longer than MAX_BURST beats are split; the remainder
//   re-arbitrates as a fresh burst with its own header.
//
//   Optional feature macro: OUTPUT_TX_TRAILER_EN
//     When defined, every burst is followed by a trailer word
//     {8'h5A, 6'd0, grant, beats_in_burst[15:0]}. When undefined the stream is
//     header + data only.
//
//   Parameters
//     DATA_W     word width (header/trailer layouts assume 32)
//     MAX_BURST  maximum data beats per grant, 1..65535
//
//   Ports
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    output_tx_arbiter_if.master (sources, FIFO write port, status)
//
//   Timing (fifo_full low): valid in IDLE at cycle t -> header written at t+1
//   -> first data at t+2. One idle cycle separates bursts for arbitration.
//   Write data, write strobe and ready are decoded combinationally from the
//   registered state so a fifo_full assertion stalls in the same cycle.
// ----------------------------------------------------------------------------
module output_tx_arbiter #(
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    output_tx_arbiter_if.master bus
);

    localparam logic [15:0] LAST_BEAT = 16'(MAX_BURST - 1);
    localparam logic [1:0]  NO_GRANT  = 2'd3;

`ifdef OUTPUT_TX_TRAILER_EN
    typedef enum logic [1:0] {IDLE, HDR, DATA, TRL} state_t;
`else
    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
`endif

    state_t      state;
    logic [1:0]  grant_q;
    logic [1:0]  rr_ptr;    // last source granted; search starts after it
    logic [15:0] seq;       // header sequence number, wraps naturally
    logic [15:0] beat_cnt;  // data beats in the current burst

    function automatic logic [1:0] rr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // ------------------------------------------------------------------
    // Arbitration: first requester after rr_ptr, wrapping back to rr_ptr.
    // ------------------------------------------------------------------
    logic [2:0] req;
    logic [1:0] cand1, cand2, pick;

    // NOTE: every signal assigned in an always_comb gets a default at the top
    // of the block; a path that leaves one unassigned would infer a latch.
    always_comb begin
        req   = bus.src_valid & bus.src_en;
        cand1 = rr_next(rr_ptr);
        cand2 = rr_next(cand1);
        pick  = NO_GRANT;
        if (req[cand1])       pick = cand1;
        else if (req[cand2])  pick = cand2;
        else if (req[rr_ptr]) pick = rr_ptr;
    end

    // ------------------------------------------------------------------
    // Granted-source view
    // ------------------------------------------------------------------
    logic              g_valid;
    logic              g_last;
    logic [DATA_W-1:0] g_data;

    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        case (grant_q)
            2'd0: begin
                g_valid = bus.src_valid[0];
                g_last  = bus.src_last[0];
                g_data  = bus.src_data[0*DATA_W +: DATA_W];
            end
            2'd1: begin
                g_valid = bus.src_valid[1];
                g_last  = bus.src_last[1];
                g_data  = bus.src_data[1*DATA_W +: DATA_W];
            end
            2'd2: begin
                g_valid = bus.src_valid[2];
                g_last  = bus.src_last[2];
                g_data  = bus.src_data[2*DATA_W +: DATA_W];
            end
            default: ;
        endcase
    end

    // A beat is one accepted data word. src_last only counts on a real beat,
    // so a last flag presented with valid low is ignored.
    logic beat;
    logic burst_end;

    always_comb begin
        beat      = (state == DATA) && g_valid && !bus.fifo_full;
        burst_end = beat && (g_last || (beat_cnt == LAST_BEAT));
    end

    // ------------------------------------------------------------------
    // Output decode from registered state
    // ------------------------------------------------------------------
    always_comb begin
        bus.fifo_din   = '0;
        bus.fifo_wr_en = 1'b0;
        bus.src_ready  = 3'b000;
        case (state)
            HDR: begin
                bus.fifo_din   = DATA_W'({8'hA5, 6'd0, grant_q, seq});
                bus.fifo_wr_en = !bus.fifo_full;
            end
            DATA: begin
                // Shifting by NO_GRANT pushes the bit out, so no ready leaks.
                bus.src_ready  = 3'(3'b001 << grant_q) & {3{!bus.fifo_full}};
                bus.fifo_din   = g_data;
                bus.fifo_wr_en = beat;
            end
`ifdef OUTPUT_TX_TRAILER_EN
            TRL: begin
                bus.fifo_din   = DATA_W'({8'h5A, 6'd0, grant_q, beat_cnt});
                bus.fifo_wr_en = !bus.fifo_full;
            end
`endif
            default: ;
        endcase
    end

    assign bus.grant = grant_q;
    assign bus.busy  = (state != IDLE) || (req != 3'b000);

    // ------------------------------------------------------------------
    // Burst FSM
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant_q  <= NO_GRANT;
            rr_ptr   <= 2'd2;  // so source 0 wins the first arbitration
            seq      <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick != NO_GRANT) begin
                        grant_q <= pick;
                        rr_ptr  <= pick;
                        state   <= HDR;
                    end
                end
                HDR: begin
                    if (!bus.fifo_full) begin
                        seq      <= seq + 16'd1;
                        beat_cnt <= '0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 16'd1;
                        if (burst_end) begin
`ifdef OUTPUT_TX_TRAILER_EN
                            state   <= TRL;
`else
                            state   <= IDLE;
                            grant_q <= NO_GRANT;
`endif
                        end
                    end
                end
`ifdef OUTPUT_TX_TRAILER_EN
                TRL: begin
                    if (!bus.fifo_full) begin
                        state   <= IDLE;
                        grant_q <= NO_GRANT;
                    end
                end
`endif
                default: begin
                    state   <= IDLE;
                    grant_q <= NO_GRANT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_output_tx_arbiter
//   Directed bench for output_tx_arbiter. Source models pop their word queues
//   on accepted handshakes; a monitor logs every FIFO write with its cycle.
//   The DUT is built with MAX_BURST=4 so forced splits are reachable quickly.
//   Header/trailer words follow {8'hA5|8'h5A, 6'd0, grant, seq|beats}.
// ----------------------------------------------------------------------------
module tb_output_tx_arbiter;

    localparam int MAX_BURST = 4;
`ifdef OUTPUT_TX_TRAILER_EN
    localparam int TRL_WORDS = 1;
`else
    localparam int TRL_WORDS = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    output_tx_arbiter_if #(.DATA_W(32)) bus ();

    output_tx_arbiter #(.DATA_W(32), .MAX_BURST(MAX_BURST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [32:0] src_q [3][$];   // {last, data}
    logic [2:0]  acc = 3'b000;   // handshakes seen this cycle
    logic [31:0] wr_q [$];
    int          wr_cyc [$];
    logic [31:0] exp_q [$];
    int          cyc = 0;
    int          full_viol = 0;
    logic [2:0]  ready_seen = 3'b000;
    logic [2:0]  grant_seen = 3'b000;

    function automatic logic [31:0] dw(input int s, input int k);
        return 32'hD000_0000 + 32'(s << 12) + 32'(k);
    endfunction

    function automatic logic [31:0] hdr(input int g, input int s);
        return {8'hA5, 6'd0, 2'(g), 16'(s)};
    endfunction

    function automatic logic [31:0] trl(input int g, input int n);
        return {8'h5A, 6'd0, 2'(g), 16'(n)};
    endfunction

    // ---------------- monitor ----------------
    initial forever begin
        @(negedge clk);
        cyc++;
        acc = bus.src_valid & bus.src_ready;
        if (rst_n) begin
            if (bus.fifo_wr_en) begin
                wr_q.push_back(bus.fifo_din);
                wr_cyc.push_back(cyc);
            end
            if (bus.fifo_full && (bus.fifo_wr_en || bus.src_ready != 3'b000))
                full_viol++;
            ready_seen = ready_seen | bus.src_ready;
            if (bus.grant != 2'd3) grant_seen[bus.grant] = 1'b1;
        end
    end

    // ---------------- source driver ----------------
    task automatic drive_sources();
        logic [2:0]  v = 3'b000;
        logic [2:0]  l = 3'b000;
        logic [95:0] d = '0;
        for (int i = 0; i < 3; i++) begin
            if (src_q[i].size() != 0) begin
                v[i]          = 1'b1;
                l[i]          = src_q[i][0][32];
                d[32*i +: 32] = src_q[i][0][31:0];
            end
        end
        bus.src_valid = v;
        bus.src_last  = l;
        bus.src_data  = d;
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            if (acc[i] && src_q[i].size() != 0) src_q[i].delete(0);
        drive_sources();
    end

    // ---------------- helpers (stimulus / expectation building) ----------------
    task automatic push_src(input int s, input int n, input int blen);
        for (int k = 0; k < n; k++)
            src_q[s].push_back({((k + 1) % blen == 0) || (k == n - 1), dw(s, k)});
    endtask

    task automatic exp_burst(input int g, input int s, input int k0, input int n);
        exp_q.push_back(hdr(g, s));
        for (int k = 0; k < n; k++) exp_q.push_back(dw(g, k0 + k));
`ifdef OUTPUT_TX_TRAILER_EN
        exp_q.push_back(trl(g, n));
`endif
    endtask

    task automatic clear_logs();
        wr_q.delete();
        wr_cyc.delete();
        exp_q.delete();
        full_viol  = 0;
        ready_seen = 3'b000;
        grant_seen = 3'b000;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) src_q[i].delete();
        bus.src_valid = '0;
        bus.src_last  = '0;
        bus.src_data  = '0;
        bus.src_en    = 3'b111;
        bus.fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 clear_logs();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        repeat (3) @(negedge clk);
        while (!(bus.grant == 2'd3 && !bus.busy)) begin
            @(negedge clk);
            n++;
            if (n > 300) begin
                checks++;
                failures++;
                $display("FAIL %s_idle_timeout got=busy exp=idle", tag);
                break;
            end
        end
    endtask

    task automatic wait_writes(input int n, input string tag);
        int k = 0;
        while (wr_q.size() < n) begin
            @(posedge clk);
            #1 k++;
            if (k > 100) begin
                checks++;
                failures++;
                $display("FAIL %s_wait got=%0d writes exp=%0d", tag, wr_q.size(), n);
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.src_en    = 3'b111;
        bus.src_valid = '0;
        bus.src_last  = '0;
        bus.src_data  = '0;
        bus.fifo_full = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.grant !== 2'd3) begin
            failures++; $display("FAIL rst_grant got=%0d exp=3", bus.grant);
        end
        checks++;
        if (bus.fifo_wr_en !== 1'b0) begin
            failures++; $display("FAIL rst_wr_en got=%b exp=0", bus.fifo_wr_en);
        end
        checks++;
        if (bus.fifo_din !== 32'h0) begin
            failures++; $display("FAIL rst_din got=%h exp=00000000", bus.fifo_din);
        end
        checks++;
        if (bus.src_ready !== 3'b000) begin
            failures++; $display("FAIL rst_ready got=%b exp=000", bus.src_ready);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy);
        end
        apply_reset();
        checks++;
        if (bus.grant !== 2'd3 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL rst_release got=grant%0d/busy%b exp=grant3/busy0", bus.grant, bus.busy);
        end
    endtask

    task automatic test_single_source();
        apply_reset();
        push_src(1, 4, 4);
        exp_burst(1, 0, 0, 4);
        wait_idle("t1");
        checks++;
        if (wr_q.size() != exp_q.size()) begin
            failures++; $display("FAIL t1_count got=%0d exp=%0d", wr_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= wr_q.size() || wr_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL t1_word%0d got=%h exp=%h", i, (i < wr_q.size()) ? wr_q[i] : 32'hx, exp_q[i]);
            end
        end
        checks++;
        if (ready_seen !== 3'b010) begin
            failures++; $display("FAIL t1_ready_mask got=%b exp=010", ready_seen);
        end
        checks++;
        if (bus.grant !== 2'd3) begin
            failures++; $display("FAIL t1_grant_end got=%0d exp=3", bus.grant);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int s = 0; s < 3; s++) push_src(s, 4, 2);
        exp_burst(0, 0, 0, 2);
        exp_burst(1, 1, 0, 2);
        exp_burst(2, 2, 0, 2);
        exp_burst(0, 3, 2, 2);
        exp_burst(1, 4, 2, 2);
        exp_burst(2, 5, 2, 2);
        wait_idle("t2");
        checks++;
        if (wr_q.size() != exp_q.size()) begin
            failures++; $display("FAIL t2_count got=%0d exp=%0d", wr_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= wr_q.size() || wr_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL t2_word%0d got=%h exp=%h", i, (i < wr_q.size()) ? wr_q[i] : 32'hx, exp_q[i]);
            end
        end
        // header of each burst lands two cycles after the previous write
        for (int b = 1; b < 6; b++) begin
            int h = b * (3 + TRL_WORDS);
            checks++;
            if (h >= wr_cyc.size() || wr_cyc[h] != wr_cyc[h - 1] + 2) begin
                failures++;
                $display("FAIL t2_gap%0d got=%0d exp=%0d", b,
                         (h < wr_cyc.size()) ? wr_cyc[h] - wr_cyc[h - 1] : -1, 2);
            end
        end
    endtask

    task automatic test_forced_split();
        apply_reset();
        push_src(2, 10, 10);
        exp_burst(2, 0, 0, 4);
        exp_burst(2, 1, 4, 4);
        exp_burst(2, 2, 8, 2);
        wait_idle("t3");
        checks++;
        if (wr_q.size() != exp_q.size()) begin
            failures++; $display("FAIL t3_count got=%0d exp=%0d", wr_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= wr_q.size() || wr_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL t3_word%0d got=%h exp=%h", i, (i < wr_q.size()) ? wr_q[i] : 32'hx, exp_q[i]);
            end
        end
    endtask

    task automatic test_fifo_full();
        apply_reset();
        push_src(0, 4, 4);
        exp_burst(0, 0, 0, 4);
        wait_writes(2, "t4");
        bus.fifo_full = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (wr_q.size() != 2) begin
            failures++; $display("FAIL t4_stall_writes got=%0d exp=2", wr_q.size());
        end
        checks++;
        if (bus.grant !== 2'd0) begin
            failures++; $display("FAIL t4_stall_grant got=%0d exp=0", bus.grant);
        end
        bus.fifo_full = 1'b0;
        wait_idle("t4");
        checks++;
        if (full_viol != 0) begin
            failures++; $display("FAIL t4_full_activity got=%0d exp=0", full_viol);
        end
        checks++;
        if (wr_q.size() != exp_q.size()) begin
            failures++; $display("FAIL t4_count got=%0d exp=%0d", wr_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= wr_q.size() || wr_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL t4_word%0d got=%h exp=%h", i, (i < wr_q.size()) ? wr_q[i] : 32'hx, exp_q[i]);
            end
        end
    endtask

    task automatic test_src_en();
        apply_reset();
        bus.src_en = 3'b110;
        push_src(0, 2, 2);
        push_src(1, 4, 4);
        push_src(2, 2, 2);
        exp_burst(1, 0, 0, 4);
        exp_burst(2, 1, 0, 2);
        wait_writes(2, "t5");
        bus.src_en = 3'b100;  // drop src1 mid-burst
        wait_idle("t5");
        checks++;
        if (grant_seen[0] !== 1'b0) begin
            failures++; $display("FAIL t5_src0_granted got=1 exp=0");
        end
        checks++;
        if (src_q[0].size() != 2) begin
            failures++; $display("FAIL t5_src0_words got=%0d exp=2", src_q[0].size());
        end
        checks++;
        if (wr_q.size() != exp_q.size()) begin
            failures++; $display("FAIL t5_count got=%0d exp=%0d", wr_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= wr_q.size() || wr_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL t5_word%0d got=%h exp=%h", i, (i < wr_q.size()) ? wr_q[i] : 32'hx, exp_q[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        push_src(0, 4, 4);
        wait_writes(2, "t6");
        #2 rst_n = 1'b0;  // between clock edges, mid-DATA
        for (int i = 0; i < 3; i++) src_q[i].delete();
        bus.src_valid = 3'b000;
        #1;
        checks++;
        if (bus.grant !== 2'd3) begin
            failures++; $display("FAIL t6_grant got=%0d exp=3", bus.grant);
        end
        checks++;
        if (bus.fifo_wr_en !== 1'b0 || bus.fifo_din !== 32'h0) begin
            failures++; $display("FAIL t6_fifo got=%b/%h exp=0/00000000", bus.fifo_wr_en, bus.fifo_din);
        end
        checks++;
        if (bus.src_ready !== 3'b000 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL t6_ready_busy got=%b/%b exp=000/0", bus.src_ready, bus.busy);
        end
        // after release: seq and round-robin pointer start over
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 clear_logs();
        push_src(1, 2, 2);
        push_src(0, 2, 2);
        exp_burst(0, 0, 0, 2);
        exp_burst(1, 1, 0, 2);
        wait_idle("t6");
        checks++;
        if (wr_q.size() != exp_q.size()) begin
            failures++; $display("FAIL t6_count got=%0d exp=%0d", wr_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= wr_q.size() || wr_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL t6_word%0d got=%h exp=%h", i, (i < wr_q.size()) ? wr_q[i] : 32'hx, exp_q[i]);
            end
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        test_reset();
        test_single_source();
        test_round_robin();
        test_forced_split();
        test_fifo_full();
        test_src_en();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
